// File: rtl/aec_pkg.sv
// aec_pkg: ASCII codes, operator encodings, precedence and FSM states
// shared by the stream expression evaluator and its stacks.
package aec_pkg;

   typedef enum logic [1:0] {
      S_ACCEPT,
      S_REDUCE,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [2:0] OP_LP  = 3'd0;
   localparam logic [2:0] OP_ADD = 3'd1;
   localparam logic [2:0] OP_SUB = 3'd2;
   localparam logic [2:0] OP_MUL = 3'd3;
   localparam logic [2:0] OP_DIV = 3'd4;
   localparam logic [2:0] OP_RP  = 3'd5;
   localparam logic [2:0] OP_EQ  = 3'd6;

   localparam logic [7:0] CH_LP  = 8'h28;
   localparam logic [7:0] CH_RP  = 8'h29;
   localparam logic [7:0] CH_MUL = 8'h2a;
   localparam logic [7:0] CH_ADD = 8'h2b;
   localparam logic [7:0] CH_SUB = 8'h2d;
   localparam logic [7:0] CH_DIV = 8'h2f;
   localparam logic [7:0] CH_EQ  = 8'h3d;
   localparam logic [7:0] CH_0   = 8'h30;
   localparam logic [7:0] CH_9   = 8'h39;
   localparam logic [7:0] CH_A   = 8'h61;
   localparam logic [7:0] CH_F   = 8'h66;

   localparam logic [2:0] E_OK     = 3'd0;
   localparam logic [2:0] E_CHAR   = 3'd1;
   localparam logic [2:0] E_SYNTAX = 3'd2;
   localparam logic [2:0] E_OVF    = 3'd3;
   localparam logic [2:0] E_DIV0   = 3'd4;

   // ')' and '=' rank 0 so they flush every pending operator
   function automatic logic [1:0] prec(input logic [2:0] op);
      logic [1:0] p;
      p = 2'd0;
      unique case (op)
         OP_MUL, OP_DIV: p = 2'd2;
         OP_ADD, OP_SUB: p = 2'd1;
         default:        p = 2'd0;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/aec_lifo.sv
// aec_lifo: register-file stack; a pop of two plus a push of one in
// the same cycle replaces both top entries with a single new value.
module aec_lifo #(
   parameter int W     = 16,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       push,
   input  logic [1:0]                 pop,
   input  logic [W-1:0]               din,
   output logic [W-1:0]               top,
   output logic [W-1:0]               sec,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [CW-1:0] base;
   logic [AW-1:0] i1;
   logic [AW-1:0] i2;
   logic          wr;

   assign base  = count - CW'(pop);
   assign wr    = push && (base < CW'(DEPTH));
   assign i1    = AW'(count - CW'(1));
   assign i2    = AW'(count - CW'(2));
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign top   = empty ? '0 : mem[i1];
   assign sec   = (count < CW'(2)) ? '0 : mem[i2];

   always_ff @(posedge clk) begin
      if (wr) mem[AW'(base)] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else begin
         count <= base + CW'(wr);
      end
   end

endmodule

// File: rtl/aec_stream_eval.sv
// aec_stream_eval: streaming two-stack infix evaluator over ASCII hex.
// Define AEC_DIV_EN to accept '/' and build the combinational divider.
module aec_stream_eval
   import aec_pkg::*;
#(
   parameter int DW    = 16,
   parameter int DEPTH = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [7:0]    ascii_in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] result,
   output logic [2:0]    err_code
);
   localparam int CW = $clog2(DEPTH+1);

   state_t        state;
   logic          live;
   logic [DW-1:0] num;
   logic          num_pend;
   logic [2:0]    pend_op;
   logic [2:0]    err;
   logic [2:0]    fault;
   logic          xfer;
   logic          is_dig;
   logic          is_lp;
   logic          is_brk;
   logic          is_eq;
   logic [3:0]    dval;
   logic [2:0]    ccode;
   logic          reduce_now;
   logic [DW-1:0] alu;
   logic          clr;

   logic          v_push, o_push;
   logic [1:0]    v_pop, o_pop;
   logic [DW-1:0] v_din, v_top, v_sec;
   logic [2:0]    o_din, o_top, o_sec;
   logic [CW-1:0] v_cnt, o_cnt;
   logic          v_full, v_empty, o_full, o_empty;
   logic          unused_ok;

   assign in_ready  = live && (state == S_ACCEPT || state == S_ERR);
   assign out_valid = (state == S_DONE);
   assign xfer      = in_valid && in_ready;
   assign is_eq     = (ascii_in == CH_EQ);
   assign unused_ok = ^{o_sec, o_cnt, v_empty};

   always_comb begin
      is_dig = 1'b0;
      is_lp  = 1'b0;
      is_brk = 1'b0;
      dval   = 4'd0;
      ccode  = OP_EQ;
      unique case (1'b1)
         (ascii_in >= CH_0 && ascii_in <= CH_9): begin
            is_dig = 1'b1;
            dval   = 4'(ascii_in - CH_0);
         end
         (ascii_in >= CH_A && ascii_in <= CH_F): begin
            is_dig = 1'b1;
            dval   = 4'(ascii_in - CH_A + 8'd10);
         end
         (ascii_in == CH_LP):  is_lp = 1'b1;
         (ascii_in == CH_RP):  begin is_brk = 1'b1; ccode = OP_RP;  end
         (ascii_in == CH_MUL): begin is_brk = 1'b1; ccode = OP_MUL; end
         (ascii_in == CH_ADD): begin is_brk = 1'b1; ccode = OP_ADD; end
         (ascii_in == CH_SUB): begin is_brk = 1'b1; ccode = OP_SUB; end
`ifdef AEC_DIV_EN
         (ascii_in == CH_DIV): begin is_brk = 1'b1; ccode = OP_DIV; end
`endif
         (ascii_in == CH_EQ):  begin is_brk = 1'b1; ccode = OP_EQ;  end
         default: ;
      endcase
   end

   always_comb begin
      alu = '0;
      unique case (o_top)
         OP_ADD:  alu = v_sec + v_top;
         OP_SUB:  alu = v_sec - v_top;
         OP_MUL:  alu = v_sec * v_top;
`ifdef AEC_DIV_EN
         OP_DIV:  alu = (v_top == '0) ? '0 : v_sec / v_top;
`endif
         default: alu = '0;
      endcase
   end

   assign reduce_now = !o_empty && (o_top != OP_LP) &&
                       (prec(o_top) >= prec(pend_op));

   // Stack strobes and the error raised this cycle, if any
   always_comb begin
      v_push = 1'b0;
      v_pop  = 2'd0;
      v_din  = num;
      o_push = 1'b0;
      o_pop  = 2'd0;
      o_din  = pend_op;
      fault  = E_OK;
      clr    = 1'b0;
      unique case (state)
         S_ACCEPT: begin
            if (xfer) begin
               if (is_lp) begin
                  if (o_full) fault = E_OVF;
                  else begin
                     o_push = 1'b1;
                     o_din  = OP_LP;
                  end
               end else if (is_brk && num_pend) begin
                  if (v_full) fault = E_OVF;
                  else v_push = 1'b1;
               end else if (!is_dig && !is_brk) begin
                  fault = E_CHAR;
               end
            end
         end
         S_REDUCE: begin
            if (reduce_now) begin
               if (v_cnt < CW'(2)) fault = E_SYNTAX;
`ifdef AEC_DIV_EN
               else if (o_top == OP_DIV && v_top == '0) fault = E_DIV0;
`endif
               else begin
                  v_pop  = 2'd2;
                  v_push = 1'b1;
                  v_din  = alu;
                  o_pop  = 2'd1;
               end
            end else if (pend_op == OP_RP) begin
               if (o_empty) fault = E_SYNTAX;
               else o_pop = 2'd1;
            end else if (pend_op == OP_EQ) begin
               if (!o_empty || v_cnt != CW'(1)) fault = E_SYNTAX;
            end else begin
               if (o_full) fault = E_OVF;
               else o_push = 1'b1;
            end
         end
         S_DONE:  clr = out_ready;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_ACCEPT;
         live     <= 1'b0;
         num      <= '0;
         num_pend <= 1'b0;
         pend_op  <= OP_EQ;
         err      <= E_OK;
         result   <= '0;
         err_code <= E_OK;
      end else begin
         live <= 1'b1;
         unique case (state)
            S_ACCEPT: begin
               if (xfer) begin
                  if (fault != E_OK) begin
                     err <= fault;
                     if (is_eq) begin
                        state    <= S_DONE;
                        err_code <= fault;
                        result   <= '0;
                     end else begin
                        state <= S_ERR;
                     end
                  end else if (is_dig) begin
                     num      <= {num[DW-5:0], dval};
                     num_pend <= 1'b1;
                  end else if (is_brk) begin
                     num      <= '0;
                     num_pend <= 1'b0;
                     pend_op  <= ccode;
                     state    <= S_REDUCE;
                  end
               end
            end
            S_REDUCE: begin
               // A fault while flushing '=' has already consumed the terminator
               if (fault != E_OK) begin
                  err <= fault;
                  if (pend_op == OP_EQ) begin
                     state    <= S_DONE;
                     err_code <= fault;
                     result   <= '0;
                  end else begin
                     state <= S_ERR;
                  end
               end else if (!reduce_now) begin
                  if (pend_op == OP_EQ) begin
                     state    <= S_DONE;
                     err_code <= E_OK;
                     result   <= v_top;
                  end else begin
                     state <= S_ACCEPT;
                  end
               end
            end
            S_ERR: begin
               if (xfer && is_eq) begin
                  state    <= S_DONE;
                  err_code <= err;
                  result   <= '0;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state    <= S_ACCEPT;
                  num      <= '0;
                  num_pend <= 1'b0;
                  err      <= E_OK;
                  err_code <= E_OK;
                  result   <= '0;
               end
            end
            default: state <= S_ACCEPT;
         endcase
      end
   end

   aec_lifo #(.W(DW), .DEPTH(DEPTH)) u_opnd (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .push  (v_push),
      .pop   (v_pop),
      .din   (v_din),
      .top   (v_top),
      .sec   (v_sec),
      .count (v_cnt),
      .full  (v_full),
      .empty (v_empty)
   );

   aec_lifo #(.W(3), .DEPTH(DEPTH)) u_oper (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .push  (o_push),
      .pop   (o_pop),
      .din   (o_din),
      .top   (o_top),
      .sec   (o_sec),
      .count (o_cnt),
      .full  (o_full),
      .empty (o_empty)
   );

endmodule

// File: tb/tb_aec_stream_eval.sv
// tb_aec_stream_eval: directed and random expressions against a
// queue-based infix evaluator; DEPTH=4 so stack overflow is reachable.
module tb_aec_stream_eval;
   localparam int DW    = 16;
   localparam int DEPTH = 4;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic          in_valid  = 1'b0;
   logic          in_ready;
   logic [7:0]    ascii_in  = 8'h00;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] result;
   logic [2:0]    err_code;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   aec_stream_eval #(.DW(DW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ascii_in  (ascii_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .err_code  (err_code)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit is_binop(input byte c);
`ifdef AEC_DIV_EN
      return c == "+" || c == "-" || c == "*" || c == "/";
`else
      return c == "+" || c == "-" || c == "*";
`endif
   endfunction

   function automatic int tprec(input byte c);
      if (c == "*" || c == "/") return 2;
      if (c == "+" || c == "-") return 1;
      return 0;
   endfunction

   function automatic int hexval(input byte c);
      if (c >= "0" && c <= "9") return int'(c) - 48;
      if (c >= "a" && c <= "f") return int'(c) - 87;
      return -1;
   endfunction

   function automatic logic [DW-1:0] apply(input byte op,
                                           input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
      logic [DW-1:0] r;
      case (op)
         "+":     r = a + b;
         "-":     r = a - b;
         "*":     r = a * b;
         default: r = a / b;
      endcase
      return r;
   endfunction

   // Reference: operator-precedence evaluation of the whole string
   task automatic model(input string s, output logic [DW-1:0] r,
                        output logic [2:0] e);
      logic [DW-1:0] vs[$];
      byte           os[$];
      logic [DW-1:0] num;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      bit            pend;
      byte           c;
      int            d;
      r = '0; e = 3'd0; num = '0; pend = 1'b0;
      for (int i = 0; i < s.len(); i++) begin
         c = s[i];
         if (e != 0) continue;
         d = hexval(c);
         if (d >= 0) begin
            num  = DW'(num * 16 + d);
            pend = 1'b1;
         end else if (c == "(") begin
            if (os.size() == DEPTH) e = 3'd3;
            else os.push_back(c);
         end else if (is_binop(c) || c == ")" || c == "=") begin
            if (pend) begin
               if (vs.size() == DEPTH) e = 3'd3;
               else vs.push_back(num);
               pend = 1'b0;
               num  = '0;
            end
            while (e == 0 && os.size() > 0 && os[$] != "(" &&
                   tprec(os[$]) >= tprec(c)) begin
               if (vs.size() < 2) e = 3'd2;
               else begin
                  b = vs[$];
                  a = vs[$-1];
                  if (os[$] == "/" && b == 0) e = 3'd4;
                  else begin
                     void'(vs.pop_back());
                     void'(vs.pop_back());
                     vs.push_back(apply(os[$], a, b));
                     void'(os.pop_back());
                  end
               end
            end
            if (e == 0) begin
               if (c == ")") begin
                  if (os.size() == 0) e = 3'd2;
                  else void'(os.pop_back());
               end else if (c == "=") begin
                  if (os.size() != 0 || vs.size() != 1) e = 3'd2;
                  else r = vs[0];
               end else if (os.size() == DEPTH) e = 3'd3;
               else os.push_back(c);
            end
         end else begin
            e = 3'd1;
         end
      end
      if (e != 0) r = '0;
   endtask

   task automatic send(input byte c, input int gap);
      int n;
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      ascii_in = c;
      n = 0;
      while (!in_ready && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (n >= 60) check("in_ready_wait", 32'd0, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_str(input string s, input int maxgap);
      for (int i = 0; i < s.len(); i++)
         send(s[i], (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
   endtask

   task automatic recv(input string tag, input logic [DW-1:0] er,
                       input logic [2:0] ee, input int hold);
      int n;
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_err"}, 32'(err_code), 32'(ee));
      check({tag, "_res"}, 32'(result), 32'(er));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, "_hold_v"}, 32'(out_valid), 32'd1);
         check({tag, "_hold_r"}, 32'(result), 32'(er));
         check({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_clr"}, 32'(out_valid), 32'd0);
   endtask

   task automatic run(input string s, input logic [DW-1:0] er,
                      input logic [2:0] ee, input int maxgap);
      logic [DW-1:0] mr;
      logic [2:0]    me;
      model(s, mr, me);
      check({s, "_model_r"}, 32'(mr), 32'(er));
      check({s, "_model_e"}, 32'(me), 32'(ee));
      send_str(s, maxgap);
      recv(s, er, ee, 0);
   endtask

   function automatic string rnd_num();
      string hx;
      string s;
      int    k;
      hx = "0123456789abcdef";
      s  = "";
      for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
         k = $urandom_range(0, 15);
         s = {s, hx.substr(k, k)};
      end
      return s;
   endfunction

   function automatic string rnd_op();
      string ops;
      int    k;
`ifdef AEC_DIV_EN
      ops = "+-*/";
      k = $urandom_range(0, 3);
`else
      ops = "+-*";
      k = $urandom_range(0, 2);
`endif
      return ops.substr(k, k);
   endfunction

   function automatic string rnd_expr();
      string s;
      int    t;
      s = ($urandom_range(0, 15) == 0) ? "+" : "";
      t = $urandom_range(1, 4);
      for (int i = 0; i < t; i++) begin
         if (i > 0) s = {s, rnd_op()};
         if ($urandom_range(0, 3) == 0)
            s = {s, "(", rnd_num(), rnd_op(), rnd_num(), ")"};
         else
            s = {s, rnd_num()};
      end
      if ($urandom_range(0, 12) == 0) s = {s, "z1"};
      return {s, "="};
   endfunction

   initial begin
      int            cnt;
      string         s;
      logic [DW-1:0] mr;
      logic [2:0]    me;

      repeat (3) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_err", 32'(err_code), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);

      send_str("1+2*3=", 0);
      cnt = 1;
      while (!out_valid && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      check("latency", 32'(cnt), 32'd4);
      recv("prec", 16'd7, 3'd0, 0);

      run("(a+5)*(3-1)=", 16'h001e, 3'd0, 0);
      run("ff*10=", 16'h0ff0, 3'd0, 0);
      run("0-1=", 16'hffff, 3'd0, 0);
      run("3+x4=", 16'h0000, 3'd1, 0);
      run("2+2=", 16'h0004, 3'd0, 0);
      run("(1+2=", 16'h0000, 3'd2, 0);
      run("1+)=", 16'h0000, 3'd2, 0);
      run("+3=", 16'h0000, 3'd2, 0);
      run("=", 16'h0000, 3'd2, 0);
      run("(((((1)))))=", 16'h0000, 3'd3, 0);
      run("((((1))))=", 16'h0001, 3'd0, 0);
`ifdef AEC_DIV_EN
      run("8/2-1=", 16'h0003, 3'd0, 0);
      run("5/0=", 16'h0000, 3'd4, 0);
`else
      run("8/2=", 16'h0000, 3'd1, 0);
`endif

      send_str("12*3+4=", 3);
      recv("stall", 16'h003a, 3'd0, 10);

      send_str("12+3", 2);
      rst_n = 1'b0;
      #1;
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_resume", 32'(in_ready), 32'd1);
      run("2+2=", 16'h0004, 3'd0, 1);

      for (int i = 0; i < 40; i++) begin
         s = rnd_expr();
         model(s, mr, me);
         send_str(s, (i % 3 == 0) ? 2 : 0);
         recv({"rnd_", s}, mr, me, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout observed hang expected finish");
      $fatal(1, "timeout");
   end

endmodule
